// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : ALU result capture, branch/jump resolution with PC redirect and
//            squash window, 2-entry skid buffer toward register-file writeback.
// Revision : 1.0
// ============================================================================
module alu_result_stage #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             zero,
  input  logic             less_than,
  input  logic             less_than_unsigned,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_en,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] retired
);

  localparam int SQ_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int PW   = XLEN + 5 + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     e0_q, e0_d;
  logic [PW-1:0]     e1_q, e1_d;
  logic [SQ_W-1:0]   squash_q, squash_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              br_taken;
  logic              is_jump;
  logic              take_redirect;
  logic              squashing;
  logic              accept;
  logic              drain;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   beat_data;
  logic              beat_en;
  logic [PW-1:0]     beat;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = less_than;
      3'b101:  br_taken = ~less_than;
      3'b110:  br_taken = less_than_unsigned;
      3'b111:  br_taken = ~less_than_unsigned;
      default: br_taken = 1'b0;
    endcase
    // Jumps dominate the branch flag: a jump is never treated as a branch.
    is_jump       = is_jal | is_jalr;
    take_redirect = is_jump | (is_branch & br_taken);
    target        = is_jalr ? {alu_out[XLEN-1:1], 1'b0} : (pc + imm);
    beat_data     = is_jump ? (pc + XLEN'(4)) : alu_out;
    beat_en       = reg_write & (rd != 5'd0) & ~(is_branch & ~is_jump);
    beat          = {beat_data, rd, beat_en};

    // While squashing, beats are dropped, so buffer occupancy does not gate ready.
    squashing = (squash_q != '0);
    in_ready  = rst_n & (squashing | (state_q != TWO));
    accept    = in_valid & in_ready & ~squashing;
    drain     = (state_q != EMPTY) & out_ready;
  end

  always_comb begin
    state_d          = state_q;
    e0_d             = e0_q;
    e1_d             = e1_q;
    squash_d         = squash_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    retired_d        = retired_q;

    if (in_valid && in_ready && squashing) begin
      squash_d = squash_q - SQ_W'(1);
    end

    if (accept) begin
      retired_d = retired_q + CNT_W'(1);
      if (take_redirect) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target;
        squash_d         = SQ_W'(FLUSH_CYCLES);
      end
    end

    case (state_q)
      EMPTY: begin
        if (accept) begin
          e0_d    = beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          e0_d = beat;
        end else if (accept) begin
          e1_d    = beat;
          state_d = TWO;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          e0_d    = e1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= EMPTY;
      e0_q             <= '0;
      e1_q             <= '0;
      squash_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      retired_q        <= '0;
    end else begin
      state_q          <= state_d;
      e0_q             <= e0_d;
      e1_q             <= e1_d;
      squash_q         <= squash_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      retired_q        <= retired_d;
    end
  end

  assign out_valid              = (state_q != EMPTY);
  assign {wb_data, wb_rd, wb_en} = e0_q;
  assign redirect_valid         = redirect_valid_q;
  assign redirect_pc            = redirect_pc_q;
  assign retired                = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Purpose  : Scoreboard bench for alu_result_stage (directed + random beats).
// Revision : 1.0
// ============================================================================
module tb_alu_result_stage;

  localparam int XLEN  = 32;
  localparam int FLUSH = 2;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] alu_out = '0, pc = '0, imm = '0;
  logic zero = 0, less_than = 0, less_than_unsigned = 0;
  logic [4:0] rd = '0;
  logic [2:0] funct3 = '0;
  logic is_branch = 0, is_jal = 0, is_jalr = 0, reg_write = 0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] wb_data, redirect_pc;
  logic [4:0] wb_rd;
  logic wb_en, redirect_valid;
  logic [31:0] retired;

  alu_result_stage #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .zero(zero), .less_than(less_than),
    .less_than_unsigned(less_than_unsigned), .pc(pc), .imm(imm), .rd(rd),
    .funct3(funct3), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, pc, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit z, lt, ltu, br, jal, jalr, rw;
  } beat_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; logic en; } wb_t;
  typedef struct { int cyc; logic [31:0] tgt; } red_t;

  wb_t  wbq[$];
  red_t redq[$];
  int   checks = 0, passes = 0;
  int   cyc = 0;
  int   sq_m = 0, occ_m = 0;
  logic [31:0] ret_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: what the instruction should write back and where fetch must go.
  function automatic void ref_model(input beat_t b, output wb_t w, output bit redir,
                                    output logic [31:0] tgt);
    bit taken;
    bit jump;
    case (b.f3)
      3'd0: taken = b.z;    3'd1: taken = !b.z;
      3'd4: taken = b.lt;   3'd5: taken = !b.lt;
      3'd6: taken = b.ltu;  3'd7: taken = !b.ltu;
      default: taken = 0;
    endcase
    jump   = b.jal || b.jalr;
    redir  = jump || (b.br && taken);
    tgt    = b.jalr ? (b.alu & 32'hFFFF_FFFE) : (b.pc + b.imm);
    w.data = jump ? b.pc + 32'd4 : b.alu;
    w.rd   = b.rd;
    w.en   = b.rw && (b.rd != 0) && (jump || !b.br);
  endfunction

  // Drive one cycle; v=0 means idle. Model decides acceptance from its own state.
  task automatic send(input beat_t b, input bit v);
    wb_t w; bit redir; logic [31:0] tgt; bit exp_rdy; bit acc; bit drn;
    in_valid = v; alu_out = b.alu; pc = b.pc; imm = b.imm; rd = b.rd; funct3 = b.f3;
    zero = b.z; less_than = b.lt; less_than_unsigned = b.ltu;
    is_branch = b.br; is_jal = b.jal; is_jalr = b.jalr; reg_write = b.rw;
    @(negedge clk);
    exp_rdy = (sq_m != 0) || (occ_m < 2);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, occ_m > 0);
    chk("retired", retired, ret_m);
    acc = 0;
    if (v && exp_rdy) begin
      if (sq_m > 0) sq_m--;
      else begin
        acc = 1;
        ref_model(b, w, redir, tgt);
        wbq.push_back(w);
        ret_m++;
        if (redir) begin
          redq.push_back('{cyc + 1, tgt});
          sq_m = FLUSH;
        end
      end
    end
    drn = (occ_m > 0) && out_ready;
    occ_m = occ_m + int'(acc) - int'(drn);
    @(posedge clk); #1;
  endtask

  // Monitor: independent of stimulus, compares whatever the DUT presents.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (wbq.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          e = wbq.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_en", wb_en, e.en);
        end
      end
      if (redq.size() != 0 && redq[0].cyc == cyc) begin
        chk("redirect_valid", redirect_valid, 1);
        chk("redirect_pc", redirect_pc, redq[0].tgt);
        void'(redq.pop_front());
      end else begin
        chk("redirect_idle", redirect_valid, 0);
      end
    end
  end

  function automatic beat_t mk(input logic [31:0] a, p, i, input logic [4:0] r,
                               input logic [2:0] f, input bit z, lt, ltu, br, jal, jalr, rw);
    beat_t b;
    b.alu = a; b.pc = p; b.imm = i; b.rd = r; b.f3 = f; b.z = z; b.lt = lt; b.ltu = ltu;
    b.br = br; b.jal = jal; b.jalr = jalr; b.rw = rw;
    return b;
  endfunction

  function automatic beat_t rnd();
    beat_t b; int k;
    b = mk($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           0, 0, 0, bit'($urandom_range(0, 1)));
    k = $urandom_range(0, 9);
    if (k == 0) b.jal = 1;
    else if (k == 1) b.jalr = 1;
    else if (k <= 4) b.br = 1;
    if ($urandom_range(0, 9) == 0) b.jal = 1;  // occasionally jump+branch together
    return b;
  endfunction

  task automatic do_reset(input int n);
    beat_t nb;
    nb = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0; in_valid = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("in_ready_in_reset", in_ready, 0);
      @(posedge clk); #1;
    end
    wbq.delete(); redq.delete();
    sq_m = 0; occ_m = 0; ret_m = '0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_wb", {wb_data, wb_rd, wb_en}, 0);
    chk("rst_retired", retired, 0);
    rst_n = 1;
    if (nb.rw) in_valid = 0;
  endtask

  beat_t idle_b, filler;

  initial begin
    idle_b = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    filler = mk(32'hDEAD, 32'h500, 0, 5'd9, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset(2);
    out_ready = 1;
    send(idle_b, 0);
    // ADD
    send(mk(30, 32'h10, 0, 5'd5, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    send(idle_b, 0);
    // BEQ taken, then two wrong-path beats dropped
    send(mk(0, 32'h100, 32'h20, 5'd0, 3'b000, 1, 0, 0, 1, 0, 0, 0), 1);
    send(filler, 1); send(filler, 1);
    send(idle_b, 0);
    // BLT -2 vs 1: signed taken, unsigned not taken
    send(mk(32'hFFFF_FFFD, 32'h200, 32'h40, 5'd3, 3'b100, 0, 1, 0, 1, 0, 0, 0), 1);
    send(filler, 1); send(filler, 1);
    send(mk(32'hFFFF_FFFD, 32'h200, 32'h40, 5'd3, 3'b110, 0, 1, 0, 1, 0, 0, 0), 1);
    send(idle_b, 0);
    // JALR rd=1, then rd=0
    send(mk(32'h203, 32'h40, 0, 5'd1, 0, 0, 0, 0, 0, 0, 1, 1), 1);
    send(filler, 1); send(filler, 1);
    send(mk(32'h203, 32'h40, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1), 1);
    send(filler, 1); send(filler, 1);
    send(idle_b, 0);
    // Backpressure: third beat refused, then resent after release
    out_ready = 0;
    send(mk(1, 0, 0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    send(mk(2, 0, 0, 5'd2, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    send(mk(3, 0, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    out_ready = 1;
    send(mk(3, 0, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    for (int i = 0; i < 3; i++) send(idle_b, 0);
    // Reset with two buffered beats and a squash pending
    out_ready = 0;
    send(mk(7, 0, 0, 5'd7, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    send(mk(0, 32'h80, 32'h8, 5'd8, 0, 0, 0, 0, 0, 1, 0, 1), 1);
    do_reset(1);
    out_ready = 1;
    send(mk(11, 0, 0, 5'd11, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    send(idle_b, 0); send(idle_b, 0);
    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      send(rnd(), $urandom_range(0, 9) < 8);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) send(idle_b, 0);
    chk("scoreboard_empty", wbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
